// File: rtl/wb_master_ctrl_if.sv
// Command, response and Wishbone classic-cycle signals
// shared by the bus initiator and its environment.
interface wb_master_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int SW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_sel;
    logic          cmd_lock;
    logic          cmd_tag;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_status;
    logic          rsp_tag;

    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [SW-1:0] sel_o;
    logic          we_o;
    logic          cyc_o;
    logic          stb_o;
    logic          lock_o;
    logic          tagn_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;
    logic          err_i;
    logic          rty_i;
    logic          tagn_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_sel, cmd_lock, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_status, rsp_tag,
        output adr_o, dat_o, sel_o, we_o,
        output cyc_o, stb_o, lock_o, tagn_o,
        input  dat_i, ack_i, err_i, rty_i, tagn_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_sel, cmd_lock, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_status, rsp_tag,
        input  adr_o, dat_o, sel_o, we_o,
        input  cyc_o, stb_o, lock_o, tagn_o,
        output dat_i, ack_i, err_i, rty_i, tagn_i
    );
endinterface

// File: rtl/wb_master_ctrl.sv
// Wishbone classic-cycle initiator: one bus cycle per command,
// with bounded retry, timeout and a single response strobe.
module wb_master_ctrl #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int SW        = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_master_ctrl_if.master bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [RW-1:0] RTY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TMO_SAT = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic TMO_EN = (TIMEOUT > 0);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_BACKOFF,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic [SW-1:0] sel_q;
    logic          we_q;
    logic          lock_q;
    logic          tag_q;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [DW-1:0] rdata_q;
    logic [1:0]    status_q;
    logic          rtag_q;

    logic       accept;
    logic       in_bus;
    logic       t_err;
    logic       t_rty;
    logic       t_ack;
    logic       t_tmo;
    logic       can_retry;
    logic       bus_entry;
    logic [1:0] status_nx;

    // Termination priority: err > rty > ack > timeout.
    always_comb begin
        accept    = (state == S_IDLE) && bus.cmd_valid;
        in_bus    = (state == S_BUS);
        t_err     = in_bus && bus.err_i;
        t_rty     = in_bus && !bus.err_i && bus.rty_i;
        t_ack     = in_bus && !bus.err_i && !bus.rty_i && bus.ack_i;
        t_tmo     = in_bus && !bus.err_i && !bus.rty_i && !bus.ack_i
                    && TMO_EN && (tmo_cnt == TMO_LAST);
        can_retry = (retry_cnt < RTY_MAX);
        bus_entry = (state_nx == S_BUS) && (state != S_BUS);
    end

    always_comb begin
        status_nx = ST_TMO;
        unique case (1'b1)
            t_err:   status_nx = ST_ERR;
            t_rty:   status_nx = ST_RTY;
            t_ack:   status_nx = ST_OK;
            default: status_nx = ST_TMO;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nx = S_BUS;
            end
            S_BUS: begin
                if (t_rty && can_retry) begin
                    state_nx = S_BACKOFF;
                end else if (t_err || t_rty || t_ack || t_tmo) begin
                    state_nx = S_RESP;
                end
            end
            S_BACKOFF: state_nx = S_BUS;
            S_RESP:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            lock_q    <= 1'b0;
            tag_q     <= 1'b0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            rdata_q   <= '0;
            status_q  <= ST_OK;
            rtag_q    <= 1'b0;
        end else begin
            if (accept) begin
                adr_q     <= bus.cmd_addr;
                dat_q     <= bus.cmd_wdata;
                sel_q     <= bus.cmd_sel;
                we_q      <= bus.cmd_we;
                lock_q    <= bus.cmd_lock;
                tag_q     <= bus.cmd_tag;
                retry_cnt <= '0;
            end else if (t_rty && can_retry) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            // Each strobe phase gets its own full timeout window.
            if (bus_entry) begin
                tmo_cnt <= '0;
            end else if (in_bus && (tmo_cnt != TMO_SAT)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (state_nx == S_RESP) begin
                status_q <= status_nx;
                rdata_q  <= (t_ack && !we_q) ? bus.dat_i : '0;
                rtag_q   <= bus.tagn_i;
            end
        end
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.stb_o     = (state == S_BUS);
        bus.cyc_o     = (state == S_BUS)
                        || ((state == S_BACKOFF) && lock_q);
        bus.lock_o    = lock_q && bus.cyc_o;
        bus.rsp_valid = (state == S_RESP);
    end

    assign bus.adr_o      = adr_q;
    assign bus.dat_o      = dat_q;
    assign bus.sel_o      = sel_q;
    assign bus.we_o       = we_q;
    assign bus.tagn_o     = tag_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_status = status_q;
    assign bus.rsp_tag    = rtag_q;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: directed table, random scripts
// against a transaction-level model, reset and idle corners.
module tb_wb_master_ctrl;
    localparam int TMO  = 16;
    localparam int MAXR = 3;
    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_RTY = 2;
    localparam int K_SIL = 3;
    localparam int K_AE  = 4;

    typedef struct {
        logic            we;
        logic [7:0]      addr;
        logic [7:0]      wdata;
        logic [7:0]      sel;
        logic            lock;
        logic            tag;
        logic [7:0]      rdat;
        logic            stag;
        int              nph;
        logic [3:0][2:0] kind;
        logic [3:0][3:0] wt;
        int              est;
        int              erd;
        int              estb;
        int              eph;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_master_ctrl_if #(.AW(8), .DW(8), .SW(8)) bus ();

    wb_master_ctrl #(
        .AW(8), .DW(8), .SW(8),
        .MAX_RETRY(MAXR), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [7:0] addr, input logic [7:0] wdata,
        input logic [7:0] sel, input logic lock, input logic tag,
        input logic [7:0] rdat, input logic stag, input int nph,
        input int k0, input int w0, input int k1, input int w1,
        input int k2, input int w2, input int k3, input int w3,
        input int est, input int erd, input int estb, input int eph);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.lock = lock; v.tag = tag; v.rdat = rdat; v.stag = stag;
        v.nph = nph;
        v.kind[0] = 3'(k0); v.wt[0] = 4'(w0);
        v.kind[1] = 3'(k1); v.wt[1] = 4'(w1);
        v.kind[2] = 3'(k2); v.wt[2] = 4'(w2);
        v.kind[3] = 3'(k3); v.wt[3] = 4'(w3);
        v.est = est; v.erd = erd; v.estb = estb; v.eph = eph;
        return v;
    endfunction

    // Walk the slave script phase by phase; unscripted phases are silent.
    function automatic void model(inout vec_t v);
        int r = 0;
        int k;
        int w;
        v.est = -1; v.estb = 0; v.eph = 0;
        for (int p = 0; v.est < 0; p++) begin
            k = (p < v.nph) ? int'(v.kind[p]) : K_SIL;
            w = (p < v.nph) ? int'(v.wt[p]) : 0;
            v.eph++;
            if (k == K_SIL || w >= TMO) begin
                v.estb += TMO;
                v.est = 3;
            end else begin
                v.estb += w + 1;
                if (k == K_ERR || k == K_AE) v.est = 1;
                else if (k == K_RTY) begin
                    if (r < MAXR) r++;
                    else v.est = 2;
                end else v.est = 0;
            end
        end
        v.erd = (v.est == 0 && !v.we) ? int'(v.rdat) : 0;
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int  ph = 0, c = 0, stbs = 0, phs = 0, gaps = 0;
        int  first = -1, rsp_at = -1, st = -1, rd = -1, tg = -1;
        bit  prev = 0, done = 0, fbad = 0, lbad = 0;
        @(negedge clk);
        bus.cmd_we = v.we; bus.cmd_addr = v.addr;
        bus.cmd_wdata = v.wdata; bus.cmd_sel = v.sel;
        bus.cmd_lock = v.lock; bus.cmd_tag = v.tag;
        bus.dat_i = v.rdat; bus.tagn_i = v.stag;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 50 && !bus.cmd_ready; k++) @(negedge clk);
        check({nm, ".accept"}, int'(bus.cmd_ready), 1);
        if (!bus.cmd_ready) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0;
            if (bus.rsp_valid) begin
                done = 1; rsp_at = i;
                st = int'(bus.rsp_status);
                rd = int'(bus.rsp_rdata);
                tg = int'(bus.rsp_tag);
                if (bus.cyc_o || bus.stb_o || bus.lock_o) lbad = 1;
            end else if (bus.stb_o) begin
                stbs++;
                if (!prev) phs++;
                if (first < 0) first = i;
                if (bus.adr_o !== v.addr || bus.dat_o !== v.wdata ||
                    bus.sel_o !== v.sel || bus.we_o !== v.we ||
                    bus.tagn_o !== v.tag) fbad = 1;
                if (!bus.cyc_o || bus.lock_o !== v.lock) lbad = 1;
                if (ph < v.nph && int'(v.kind[ph]) != K_SIL &&
                    c == int'(v.wt[ph])) begin
                    case (int'(v.kind[ph]))
                        K_ACK: bus.ack_i = 1'b1;
                        K_ERR: bus.err_i = 1'b1;
                        K_RTY: bus.rty_i = 1'b1;
                        default: begin
                            bus.ack_i = 1'b1;
                            bus.err_i = 1'b1;
                        end
                    endcase
                    ph++;
                    c = 0;
                end else begin
                    c++;
                end
            end else begin
                gaps++;
                if (bus.cyc_o !== v.lock || bus.lock_o !== v.lock) lbad = 1;
            end
            prev = bus.stb_o;
        end
        check({nm, ".rsp_seen"}, int'(done), 1);
        check({nm, ".status"}, st, v.est);
        check({nm, ".rdata"}, rd, v.erd);
        if (v.est == 0) check({nm, ".tag"}, tg, int'(v.stag));
        check({nm, ".stb_cycles"}, stbs, v.estb);
        check({nm, ".stb_phases"}, phs, v.eph);
        check({nm, ".gaps"}, gaps, v.eph - 1);
        check({nm, ".first_stb"}, first, 0);
        check({nm, ".rsp_cycle"}, rsp_at, v.estb + v.eph - 1);
        check({nm, ".bus_fields"}, int'(fbad), 0);
        check({nm, ".cyc_lock"}, int'(lbad), 0);
        @(negedge clk);
        check({nm, ".rsp_one_cycle"}, int'(bus.rsp_valid), 0);
        check({nm, ".ready_after"}, int'(bus.cmd_ready), 1);
        check({nm, ".status_held"}, int'(bus.rsp_status), v.est);
    endtask

    vec_t tbl[12];
    vec_t rv;
    int   hits;

    initial begin
        bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_addr = 0;
        bus.cmd_wdata = 0; bus.cmd_sel = 0; bus.cmd_lock = 0;
        bus.cmd_tag = 0; bus.dat_i = 0; bus.ack_i = 0;
        bus.err_i = 0; bus.rty_i = 0; bus.tagn_i = 0;

        tbl[0]  = mk(1, 8'h10, 8'hA5, 8'hFF, 0, 0, 8'h00, 0, 1,
                     K_ACK, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        tbl[1]  = mk(0, 8'h22, 8'h00, 8'h01, 0, 1, 8'h3C, 1, 1,
                     K_ACK, 0, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 1, 1);
        tbl[2]  = mk(0, 8'h30, 8'h00, 8'hFF, 0, 0, 8'h5A, 0, 3,
                     K_RTY, 0, K_RTY, 1, K_ACK, 0, 0, 0, 0, 8'h5A, 4, 3);
        tbl[3]  = mk(1, 8'h31, 8'h77, 8'h0F, 0, 1, 8'h00, 0, 4,
                     K_RTY, 0, K_RTY, 0, K_RTY, 0, K_RTY, 0, 2, 0, 4, 4);
        tbl[4]  = mk(1, 8'h40, 8'hC3, 8'hFF, 1, 0, 8'h00, 0, 2,
                     K_RTY, 1, K_ACK, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        tbl[5]  = mk(0, 8'h50, 8'h00, 8'hFF, 0, 0, 8'h99, 1, 1,
                     K_SIL, 0, 0, 0, 0, 0, 0, 0, 3, 0, 16, 1);
        tbl[6]  = mk(0, 8'h60, 8'h00, 8'hFF, 0, 0, 8'h88, 1, 1,
                     K_AE, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1);
        tbl[7]  = mk(1, 8'h61, 8'h12, 8'h03, 0, 0, 8'h00, 0, 1,
                     K_ERR, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        tbl[8]  = mk(0, 8'h70, 8'h00, 8'hFF, 1, 1, 8'h44, 0, 4,
                     K_RTY, 0, K_RTY, 0, K_RTY, 2, K_RTY, 0, 2, 0, 6, 4);
        tbl[9]  = mk(0, 8'h71, 8'h00, 8'hFF, 0, 0, 8'h11, 0, 1,
                     K_RTY, 0, 0, 0, 0, 0, 0, 0, 3, 0, 17, 2);
        tbl[10] = mk(0, 8'h72, 8'h00, 8'hFF, 0, 0, 8'h66, 0, 2,
                     K_RTY, 1, K_ERR, 0, 0, 0, 0, 0, 1, 0, 3, 2);
        tbl[11] = mk(0, 8'hFF, 8'h00, 8'h80, 0, 0, 8'hFF, 0, 1,
                     K_ACK, 3, 0, 0, 0, 0, 0, 0, 0, 8'hFF, 4, 1);

        repeat (3) @(negedge clk);
        check("reset.cmd_ready", int'(bus.cmd_ready), 1);
        check("reset.cyc_stb_lock",
              int'({bus.cyc_o, bus.stb_o, bus.lock_o}), 0);
        check("reset.rsp_valid", int'(bus.rsp_valid), 0);
        check("reset.bus_regs", int'({bus.adr_o, bus.dat_o, bus.sel_o,
              bus.we_o, bus.tagn_o}), 0);
        check("reset.rsp_regs", int'({bus.rsp_rdata, bus.rsp_status,
              bus.rsp_tag}), 0);
        rst_n = 1'b1;

        // Terminations while idle must not start or end anything.
        @(negedge clk);
        bus.ack_i = 1; bus.err_i = 1; bus.rty_i = 1;
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.cyc_o) hits++;
        end
        bus.ack_i = 0; bus.err_i = 0; bus.rty_i = 0;
        check("idle.term_ignored", hits, 0);

        for (int i = 0; i < 12; i++)
            run_txn(tbl[i], $sformatf("tbl%0d", i));

        for (int n = 0; n < 40; n++) begin
            int r;
            rv.we = 1'($urandom_range(0, 1));
            rv.addr = 8'($urandom); rv.wdata = 8'($urandom);
            rv.sel = 8'($urandom); rv.lock = 1'($urandom_range(0, 1));
            rv.tag = 1'($urandom_range(0, 1));
            rv.rdat = 8'($urandom); rv.stag = 1'($urandom_range(0, 1));
            rv.nph = $urandom_range(1, 4);
            for (int p = 0; p < 4; p++) begin
                r = $urandom_range(0, 9);
                rv.kind[p] = (r < 4) ? 3'(K_ACK) : (r == 4) ? 3'(K_ERR) :
                             (r < 8) ? 3'(K_RTY) : (r == 8) ? 3'(K_SIL) :
                             3'(K_AE);
                rv.wt[p] = 4'($urandom_range(0, 3));
            end
            model(rv);
            run_txn(rv, $sformatf("rnd%0d", n));
        end

        // Reset while the slave is stalling mid-cycle.
        @(negedge clk);
        bus.cmd_we = 0; bus.cmd_addr = 8'h44; bus.cmd_lock = 1;
        bus.cmd_valid = 1;
        @(negedge clk);
        bus.cmd_valid = 0;
        check("rst_mid.stb_before", int'(bus.stb_o), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid.cyc_stb", int'({bus.cyc_o, bus.stb_o, bus.lock_o}), 0);
        check("rst_mid.no_rsp", int'(bus.rsp_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.ready", int'(bus.cmd_ready), 1);
        hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.cyc_o) hits++;
        end
        check("rst_mid.quiet", hits, 0);
        run_txn(tbl[1], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
